qed_dup_sequencer: RTL and testbench

//  QED instruction transformer between the IFU fetch buffer and decode (dec.qed). Passes

---
 rtl/qed_dup_sequencer_pkg.sv | 63 ++++++
 rtl/qed_dup_fifo.sv | 66 ++++++
 rtl/qed_dup_sequencer.sv | 135 +++++++++++++
 tb/tb_qed_dup_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/qed_dup_sequencer_pkg.sv
// Shared QED definitions: mode encodings, SPARC opcode fields, state type,
// output payload and the duplicate eligibility/remap helpers.
package qed_dup_sequencer_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned OUT_W  = INST_W + 1;

  localparam logic ORIGINAL_MODE = 1'b0;
  localparam logic CHECK_MODE    = 1'b1;

  localparam logic [1:0] OP_FMT2 = 2'b00;
  localparam logic [1:0] OP_CALL = 2'b01;
  localparam logic [1:0] OP_ALU  = 2'b10;
  localparam logic [1:0] OP_MEM  = 2'b11;

  localparam logic [2:0] OP2_SETHI = 3'b100;

  typedef enum logic [1:0] {
    ST_ORIG  = 2'd0,
    ST_DUP   = 2'd1,
    ST_CHECK = 2'd2
  } state_e;

  typedef struct packed {
    logic              dup_tag;
    logic [INST_W-1:0] inst;
  } qed_out_t;

  // ALU group: op3 0x00-0x0C and 0x10-0x1C, excluding 0x19
  function automatic logic is_alu_dup(input logic [INST_W-1:0] inst);
    logic [5:0] op3;
    op3 = inst[24:19];
    if (inst[31:30] != OP_ALU || op3[5]) return 1'b0;
    if (op3[3:0] > 4'd12) return 1'b0;
    return !(op3[4] && op3[3:0] == 4'd9);
  endfunction

  function automatic logic is_sethi(input logic [INST_W-1:0] inst);
    return (inst[31:30] == OP_FMT2) && (inst[24:22] == OP2_SETHI);
  endfunction

  function automatic logic dup_eligible(input logic [INST_W-1:0] inst);
    return is_alu_dup(inst) || is_sethi(inst);
  endfunction

  // Originals must live in regs 0-15; the upper half belongs to duplicates
  function automatic logic uses_high_reg(input logic [INST_W-1:0] inst);
    if (is_sethi(inst)) return inst[29];
    return inst[29] | inst[18] | (!inst[13] & inst[4]);
  endfunction

  function automatic logic [INST_W-1:0] remap(input logic [INST_W-1:0] inst);
    logic [INST_W-1:0] r;
    r     = inst;
    r[29] = 1'b1;
    if (is_alu_dup(inst)) begin
      r[18] = 1'b1;
      if (!inst[13]) r[4] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/qed_dup_fifo.sv
// Duplicate-instruction FIFO: DEPTH entries, wrapping pointers, AW+1 bit count.
module qed_dup_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH),
  parameter int unsigned W     = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop) count_d = count_q + CW'(1);
      if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));

  // The sequencer leaves ORIG as soon as the FIFO fills, so a full push is a bug
  a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && full && !flush));

endmodule

// File: rtl/qed_dup_sequencer.sv
// QED sequencer: passes originals, queues register-remapped duplicates,
// replays them tagged, then emits one CHECK_MODE cycle.
module qed_dup_sequencer
  import qed_dup_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              exec_dup,
  input  logic              ifu_vld,
  input  logic [INST_W-1:0] ifu_inst,
  output logic              ifu_rdy,
  input  logic              dec_stall,
  output logic [OUT_W-1:0]  qed_ifu_instruction,
  output logic              vld_inst,
  output logic              mode,
  output logic              err_illegal_reg
);

  localparam int unsigned CW = AW + 1;

  state_e            state_q, state_d;
  qed_out_t          out_q, out_d;
  logic              vld_q, vld_d;
  logic              mode_q, mode_d;
  logic              err_q, err_d;

  logic              fifo_push, fifo_pop, fifo_flush;
  logic              fifo_full, fifo_empty;
  logic [INST_W-1:0] fifo_rdata;
  logic [CW-1:0]     fifo_count;
  logic              accept;

  assign ifu_rdy = !dec_stall && (state_q == ST_ORIG || !ena);
  assign accept  = ifu_vld && ifu_rdy;

  always_comb begin
    state_d    = state_q;
    out_d      = out_q;
    vld_d      = vld_q;
    mode_d     = mode_q;
    err_d      = err_q;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;

    if (!ena) begin
      state_d    = ST_ORIG;
      fifo_flush = 1'b1;
      if (!dec_stall) begin
        out_d  = '{dup_tag: 1'b0, inst: ifu_inst};
        vld_d  = ifu_vld;
        mode_d = ORIGINAL_MODE;
      end
    end else if (!dec_stall) begin
      unique case (state_q)
        ST_ORIG: begin
          vld_d  = accept;
          mode_d = ORIGINAL_MODE;
          if (accept) begin
            out_d = '{dup_tag: 1'b0, inst: ifu_inst};
            if (dup_eligible(ifu_inst)) begin
              if (uses_high_reg(ifu_inst)) err_d = 1'b1;
              else                         fifo_push = 1'b1;
            end
          end
          if (exec_dup)
            state_d = (fifo_empty && !fifo_push) ? ST_CHECK : ST_DUP;
          else if (fifo_push && fifo_count == CW'(DEPTH - 1))
            state_d = ST_DUP;
        end
        ST_DUP: begin
          mode_d = ORIGINAL_MODE;
          if (fifo_empty) begin
            vld_d   = 1'b0;
            state_d = ST_CHECK;
          end else begin
            fifo_pop = 1'b1;
            out_d    = '{dup_tag: 1'b1, inst: fifo_rdata};
            vld_d    = 1'b1;
            if (fifo_count == CW'(1)) state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          mode_d  = CHECK_MODE;
          vld_d   = 1'b0;
          state_d = ST_ORIG;
        end
        default: state_d = ST_ORIG;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ORIG;
      out_q   <= '0;
      vld_q   <= 1'b0;
      mode_q  <= ORIGINAL_MODE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
    end
  end

  qed_dup_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (INST_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (remap(ifu_inst)),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign qed_ifu_instruction = out_q;
  assign vld_inst            = vld_q;
  assign mode                = mode_q;
  assign err_illegal_reg     = err_q;

endmodule

// File: tb/tb_qed_dup_sequencer.sv
// Directed bench for qed_dup_sequencer with hand-computed expectations.
module tb_qed_dup_sequencer;
  import qed_dup_sequencer_pkg::*;

  logic        clk;
  logic        rst;
  logic        ena;
  logic        exec_dup;
  logic        ifu_vld;
  logic [31:0] ifu_inst;
  logic        ifu_rdy;
  logic        dec_stall;
  logic [32:0] qed_ifu_instruction;
  logic        vld_inst;
  logic        mode;
  logic        err_illegal_reg;

  int n_tests = 0;
  int n_fail  = 0;

  qed_dup_sequencer dut (
    .clk                 (clk),
    .rst                 (rst),
    .ena                 (ena),
    .exec_dup            (exec_dup),
    .ifu_vld             (ifu_vld),
    .ifu_inst            (ifu_inst),
    .ifu_rdy             (ifu_rdy),
    .dec_stall           (dec_stall),
    .qed_ifu_instruction (qed_ifu_instruction),
    .vld_inst            (vld_inst),
    .mode                (mode),
    .err_illegal_reg     (err_illegal_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [32:0] exp_out, input logic exp_vld);
    chk({tag, "_out"}, 64'(qed_ifu_instruction), 64'(exp_out));
    chk({tag, "_vld"}, 64'(vld_inst), 64'(exp_vld));
  endtask

  task automatic push_adds(input int n);
    for (int i = 0; i < n; i++) begin
      ifu_vld  = 1'b1;
      ifu_inst = 32'h8600_4000 | 32'(i);
      step();
    end
    ifu_vld = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; exec_dup = 1'b0; ifu_vld = 1'b0;
    ifu_inst = '0; dec_stall = 1'b0;
    step();
    rst = 1'b0;
    chk_out("rst", 33'h0, 1'b0);
    chk("rst_mode", 64'(mode), 64'(0));
    chk("rst_err", 64'(err_illegal_reg), 64'(0));
    chk("rst_rdy", 64'(ifu_rdy), 64'(1));

    // ADD %g1,%g2,%g3 then exec_dup
    ifu_vld = 1'b1; ifu_inst = 32'h8600_4002;
    step();
    chk_out("add_orig", 33'h0_8600_4002, 1'b1);
    chk("add_cnt", 64'(dut.fifo_count), 64'(1));
    ifu_vld = 1'b0; exec_dup = 1'b1;
    step();
    exec_dup = 1'b0;
    chk("add_st_dup", 64'(dut.state_q), 64'(ST_DUP));
    chk("add_rdy_dup", 64'(ifu_rdy), 64'(0));
    step();
    chk_out("add_dup", 33'h1_A604_4012, 1'b1);
    chk("add_dup_mode", 64'(mode), 64'(0));
    step();
    chk("add_check_mode", 64'(mode), 64'(1));
    chk("add_check_vld", 64'(vld_inst), 64'(0));
    step();
    chk("add_back_mode", 64'(mode), 64'(0));
    chk("add_back_st", 64'(dut.state_q), 64'(ST_ORIG));

    // SETHI duplicated, branch passed only
    ifu_vld = 1'b1; ifu_inst = 32'h0300_0000;
    step();
    chk_out("sethi_orig", 33'h0_0300_0000, 1'b1);
    ifu_inst = 32'h1080_0000;
    step();
    chk_out("br_orig", 33'h0_1080_0000, 1'b1);
    chk("br_cnt", 64'(dut.fifo_count), 64'(1));
    ifu_vld = 1'b0; exec_dup = 1'b1;
    step();
    exec_dup = 1'b0;
    step();
    chk_out("sethi_dup", 33'h1_2300_0000, 1'b1);
    step();
    chk("sethi_check", 64'(mode), 64'(1));
    step();
    chk("sethi_idle_vld", 64'(vld_inst), 64'(0));

    // 16 back-to-back ADDs fill the FIFO; stall 3 cycles mid-replay
    push_adds(16);
    chk("fill_rdy", 64'(ifu_rdy), 64'(0));
    chk("fill_st", 64'(dut.state_q), 64'(ST_DUP));
    chk("fill_cnt", 64'(dut.fifo_count), 64'(16));
    for (int i = 0; i < 16; i++) begin
      if (i == 5) begin
        dec_stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
          step();
          chk_out("stall", 33'h1_A604_4014, 1'b1);
          chk("stall_cnt", 64'(dut.fifo_count), 64'(11));
        end
        dec_stall = 1'b0;
      end
      step();
      chk_out("replay", {1'b1, 32'hA604_4010 | 32'(i)}, 1'b1);
    end
    chk("replay_empty", 64'(dut.fifo_count), 64'(0));
    step();
    chk("fill_check", 64'(mode), 64'(1));
    step();
    chk("fill_orig_st", 64'(dut.state_q), 64'(ST_ORIG));
    chk("fill_orig_mode", 64'(mode), 64'(0));

    // Illegal register in an original
    ifu_vld = 1'b1; ifu_inst = 32'hA200_4002;
    step();
    ifu_vld = 1'b0;
    chk_out("ill_orig", 33'h0_A200_4002, 1'b1);
    chk("ill_err", 64'(err_illegal_reg), 64'(1));
    chk("ill_cnt", 64'(dut.fifo_count), 64'(0));
    step(); step();
    chk("ill_sticky", 64'(err_illegal_reg), 64'(1));

    // Reset in DUP with 5 entries
    push_adds(5);
    exec_dup = 1'b1;
    step();
    exec_dup = 1'b0; dec_stall = 1'b1;
    chk("pre_rst_st", 64'(dut.state_q), 64'(ST_DUP));
    chk("pre_rst_cnt", 64'(dut.fifo_count), 64'(5));
    rst = 1'b1;
    step();
    rst = 1'b0; dec_stall = 1'b0;
    chk("mid_rst_st", 64'(dut.state_q), 64'(ST_ORIG));
    chk("mid_rst_cnt", 64'(dut.fifo_count), 64'(0));
    chk_out("mid_rst", 33'h0, 1'b0);
    chk("mid_rst_err", 64'(err_illegal_reg), 64'(0));

    // ena low: transparent passthrough, and flush from DUP
    ena = 1'b0; ifu_vld = 1'b1; ifu_inst = 32'h8600_4002;
    step();
    chk_out("pass", 33'h0_8600_4002, 1'b1);
    chk("pass_cnt", 64'(dut.fifo_count), 64'(0));
    ena = 1'b1; ifu_vld = 1'b0;
    push_adds(2);
    exec_dup = 1'b1;
    step();
    exec_dup = 1'b0;
    chk("ena_dup_st", 64'(dut.state_q), 64'(ST_DUP));
    ena = 1'b0;
    step();
    chk("ena_fall_st", 64'(dut.state_q), 64'(ST_ORIG));
    chk("ena_fall_cnt", 64'(dut.fifo_count), 64'(0));
    chk("ena_fall_vld", 64'(vld_inst), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
